msk_add_round_tweakey: RTL and testbench
========================================

// Module: msk_add_round_tweakey
// PURPOSE
//  Masked Skinny-128 AddConstants + AddRoundTweakey stage, d-share domain-oriented sharing.
//  Sits between masked SubCells and MSKShiftRows; its registered output feeds ShiftRows directly.
//  Owns the 6-bit round-constant LFSR and round counter. Applies one round per accepted transfer.
//  Never recombines shares; constants touch share 0 only, tweakey is added share-wise.
// PARAMETERS
//  d       2   number of shares (d >= 2)
//  W       8   cell width in bits (fixed 8 for Skinny-128)
//  ROUNDS  48  rounds per sequence (48 = Skinny-128-256)
// PORTS
//  clk        in   1         rising-edge clock
//  rst        in   1         synchronous, active-high reset
//  start      in   1         1-cycle pulse: begin new sequence (round 0, rc=0x01)
//  in_valid   in   1         state_in/tk_in valid
//  in_ready   out  1         stage can accept a transfer this cycle
//  state_in   in   d*128     shared state. Cell k (0..15, row-major, cell 0 = MSB), share j:
//                            bits [(15-k)*d*W + j*W +: W]
//  tk_in      in   d*64      shared round tweakey for rows 0-1. Cell k (0..7):
//                            [(7-k)*d*W + j*W +: W]
//  state_out  out  d*128     registered result, same layout as state_in
//  out_valid  out  1         state_out holds an unconsumed result
//  out_ready  in   1         downstream accepts state_out
//  round_idx  out  6         round index of the value in state_out
//  last_round out  1         state_out is round ROUNDS-1
// BEHAVIOUR
//  Reset: out_valid=0, state_out=0, round_idx=0, last_round=0, rc=6'h01, round counter=0,
//   active=0.
//  active: set by start; cleared when round ROUNDS-1 is accepted.
//  in_ready = active & (!out_valid | out_ready). With active=0, in_ready=0 regardless of out_ready.
//  Transfer when in_valid & in_ready. Latency is 1 cycle: result is in state_out the next cycle.
//  out_valid drops when out_ready=1 and no new transfer occurs in that cycle.
//  Output holds stable while out_valid & !out_ready.
//  Datapath (combinational into the output register), per cell k and share j:
//   - out[k][j] = in[k][j] ^ (k<8 ? tk[k][j] : 0)
//   - share 0 only, additionally:
//     cell 0 ^= {4'h0, rc[3:0]}; cell 4 ^= {6'h0, rc[5:4]}; cell 8 ^= 8'h02.
//  rc LFSR (advances once per transfer): rc <= {rc[4:0], rc[5]^rc[4]^1'b1}.
//   Sequence: 01,03,07,0F,1F,3E,...; round 47 uses 0x04.
//  Round counter increments per transfer; round_idx and last_round are registered with state_out.
//  start restarts the sequence: rc=01, counter=0, active=1; no wrap-around past ROUNDS-1.
//  start & transfer in the same cycle: the transfer uses rc=0x01 and round 0.
//   Afterwards rc=0x03 and counter=1.
//  start while active aborts the running sequence. A pending output stays valid until consumed.
//  Reset mid-sequence: everything returns to reset values next cycle; the pending output is lost.
//  Width rules: round counter is 6 bits; ROUNDS <= 63.
// STRUCTURE
//  skinny_msk_pkg:
//   - W, RC_INIT=6'h01, RC_CELLS={0,4,8}, C2=8'h02
//   - function cell_share_idx(k,j,d) giving the bit offset
//   - rc_next() function
//  Sub-module msk_skinny_rc_lfsr: 6-bit LFSR with load (start) and enable (transfer).
//  Top module: handshake/active FSM (IDLE/ACTIVE), counter, XOR datapath, output register.
// TESTING
//  1) d=2, all-zero shares, zero tk; start, then 1 transfer
//     -> share0 cells 0/4/8 = 01/00/02, all else 0; round_idx=0.
//  2) 48 back-to-back transfers, out_ready=1
//     -> rc seq matches the Skinny table; round 47 rc=04.
//     -> last_round=1 only on the 48th; in_ready=0 afterwards.
//  3) random shares and tk, d=3 -> XOR of shares equals unmasked Skinny AC+ART golden.
//     -> shares 1..d-1 of cells 8..15 unchanged.
//  4) out_ready=0 for 5 cycles with in_valid=1
//     -> in_ready=0, state_out stable, no rc advance; resumes in order.
//  5) start at round 20, same cycle as a transfer -> that output has round_idx=0, rc=01.
//     -> next transfer uses rc=03.
//  6) rst asserted at round 10 -> next cycle out_valid=0, state_out=0, in_ready=0 until start.

Source files
------------

// File: rtl/skinny_msk_pkg.sv
// Shared constants and helpers for the masked Skinny-128 AddConstants/AddRoundTweakey stage.
package skinny_msk_pkg;

  localparam int unsigned W        = 8;
  localparam logic [5:0]  RC_INIT  = 6'h01;
  localparam int unsigned RC_CELLS [3] = '{0, 4, 8};
  localparam logic [7:0]  C2       = 8'h02;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } state_e;

  // Bit offset of share j of cell k in a 16-cell shared vector (cell 0 in the MSBs).
  function automatic int unsigned cell_share_idx(int unsigned k, int unsigned j, int unsigned d);
    return (15 - k) * d * W + j * W;
  endfunction

  function automatic logic [5:0] rc_next(logic [5:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/msk_skinny_rc_lfsr.sv
// 6-bit Skinny round-constant LFSR; load restarts the sequence, enable advances one round.
module msk_skinny_rc_lfsr
  import skinny_msk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_en,
  output logic [5:0] o_rc
);

  logic [5:0] r_rc;

  // A load coinciding with an advance consumes RC_INIT in that same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rc <= RC_INIT;
    end else if (i_load && i_en) begin
      r_rc <= rc_next(RC_INIT);
    end else if (i_load) begin
      r_rc <= RC_INIT;
    end else if (i_en) begin
      r_rc <= rc_next(r_rc);
    end
  end

  assign o_rc = r_rc;

endmodule

// File: rtl/msk_add_round_tweakey.sv
// Masked Skinny-128 AddConstants + AddRoundTweakey with valid/ready handshake and output register.
module msk_add_round_tweakey
  import skinny_msk_pkg::*;
#(
  parameter int unsigned d      = 2,
  parameter int unsigned W      = 8,
  parameter int unsigned ROUNDS = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [d*128-1:0] state_in,
  input  logic [d*64-1:0]  tk_in,
  output logic [d*128-1:0] state_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       round_idx,
  output logic             last_round
);

  localparam logic [5:0] LastRound = 6'(ROUNDS - 1);

  state_e           r_state;
  logic [5:0]       r_cnt;
  logic [5:0]       w_rc_q;
  logic [5:0]       w_rc;
  logic [5:0]       w_round;
  logic             w_xfer;
  logic             w_last;
  logic [d*128-1:0] w_data;

  assign in_ready = (r_state == StActive) && (!out_valid || out_ready);
  assign w_xfer   = in_valid && in_ready;

  // A start in the same cycle as a transfer makes that transfer round 0.
  assign w_rc    = start ? RC_INIT : w_rc_q;
  assign w_round = start ? 6'd0 : r_cnt;
  assign w_last  = (w_round == LastRound);

  msk_skinny_rc_lfsr u_rc_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_load (start),
    .i_en   (w_xfer),
    .o_rc   (w_rc_q)
  );

  always_comb begin
    w_data = state_in;
    for (int unsigned k = 0; k < 8; k++) begin
      for (int unsigned j = 0; j < d; j++) begin
        w_data[cell_share_idx(k, j, d) +: W] ^= tk_in[cell_share_idx(k + 8, j, d) +: W];
      end
    end
    // Constants are public, so they land on share 0 only.
    w_data[cell_share_idx(RC_CELLS[0], 0, d) +: W] ^= {4'h0, w_rc[3:0]};
    w_data[cell_share_idx(RC_CELLS[1], 0, d) +: W] ^= {6'h0, w_rc[5:4]};
    w_data[cell_share_idx(RC_CELLS[2], 0, d) +: W] ^= C2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      out_valid  <= 1'b0;
      state_out  <= '0;
      round_idx  <= '0;
      last_round <= 1'b0;
    end else begin
      if (w_xfer && w_last) begin
        r_state <= StIdle;
      end else if (start) begin
        r_state <= StActive;
      end

      if (start) begin
        r_cnt <= w_xfer ? 6'd1 : 6'd0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + 6'd1;
      end

      if (w_xfer) begin
        out_valid  <= 1'b1;
        state_out  <= w_data;
        round_idx  <= w_round;
        last_round <= w_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msk_add_round_tweakey.sv
// Self-checking bench: d=2 and d=3 instances driven in lockstep, scoreboard plus directed vectors.
module tb_msk_add_round_tweakey;

  localparam logic [5:0] RC_TAB [48] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1E, 6'h3C,
    6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B, 6'h16, 6'h2C, 6'h18, 6'h30,
    6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E, 6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D,
    6'h1B, 6'h36, 6'h2D, 6'h1A, 6'h34, 6'h29, 6'h12, 6'h24, 6'h08, 6'h11, 6'h22, 6'h04};

  logic         clk = 1'b0;
  logic         rst, start, in_valid, out_ready;
  logic [255:0] st2, so2;
  logic [127:0] tk2;
  logic [383:0] st3, so3;
  logic [191:0] tk3;
  logic         ir2, ir3, ov2, ov3, lr2, lr3;
  logic [5:0]   ri2, ri3;

  always #5 clk = ~clk;

  msk_add_round_tweakey #(.d(2), .W(8), .ROUNDS(48)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir2),
    .state_in(st2), .tk_in(tk2), .state_out(so2), .out_valid(ov2), .out_ready(out_ready),
    .round_idx(ri2), .last_round(lr2)
  );

  msk_add_round_tweakey #(.d(3), .W(8), .ROUNDS(48)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(ir3),
    .state_in(st3), .tk_in(tk3), .state_out(so3), .out_valid(ov3), .out_ready(out_ready),
    .round_idx(ri3), .last_round(lr3)
  );

  typedef struct {
    logic [255:0] s2;
    logic [383:0] s3;
    logic [127:0] u3;
    logic [5:0]   rnd;
    logic         lst;
  } exp_t;

  typedef struct {
    logic [127:0] pt;
    logic [63:0]  tk;
    bit           rnd;
    logic [127:0] exp;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  task automatic check(input string nm, input logic [383:0] act, input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [383:0] mask(input logic [127:0] u, input int nc, input int dd,
                                        input bit rnd);
    logic [383:0] r;
    logic [7:0]   acc, sh;
    r = '0;
    for (int k = 0; k < nc; k++) begin
      acc = u[(nc-1-k)*8 +: 8];
      for (int j = 1; j < dd; j++) begin
        sh = rnd ? 8'($urandom) : 8'h00;
        r[((nc-1-k)*dd+j)*8 +: 8] = sh;
        acc ^= sh;
      end
      r[((nc-1-k)*dd)*8 +: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] unmask(input logic [383:0] s, input int nc, input int dd);
    logic [127:0] u;
    logic [7:0]   acc;
    u = '0;
    for (int k = 0; k < nc; k++) begin
      acc = 8'h00;
      for (int j = 0; j < dd; j++) acc ^= s[((nc-1-k)*dd+j)*8 +: 8];
      u[(nc-1-k)*8 +: 8] = acc;
    end
    return u;
  endfunction

  // Share-wise reference: every share gets its tweakey share, share 0 also gets the constants.
  function automatic logic [383:0] share_exp(input logic [383:0] s, input logic [191:0] t,
                                             input int dd, input logic [5:0] rc);
    logic [383:0] r;
    logic [7:0]   c;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < dd; j++) begin
        c = s[((15-k)*dd+j)*8 +: 8];
        if (k < 8) c ^= t[((7-k)*dd+j)*8 +: 8];
        if (j == 0 && k == 0) c ^= {4'h0, rc[3:0]};
        if (j == 0 && k == 4) c ^= {6'h0, rc[5:4]};
        if (j == 0 && k == 8) c ^= 8'h02;
        r[((15-k)*dd+j)*8 +: 8] = c;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] golden(input logic [127:0] pt, input logic [63:0] tk,
                                          input logic [5:0] rc);
    return pt ^ {tk, 64'h0} ^
           {4'h0, rc[3:0], 24'h0, 6'h0, rc[5:4], 24'h0, 8'h02, 56'h0};
  endfunction

  task automatic set_data(input logic [127:0] pt, input logic [63:0] tk, input bit rnd);
    logic [383:0] t;
    t = mask(pt, 16, 2, rnd);          st2 = t[255:0];
    t = mask({64'h0, tk}, 8, 2, rnd);  tk2 = t[127:0];
    st3 = mask(pt, 16, 3, rnd);
    t = mask({64'h0, tk}, 8, 3, rnd);  tk3 = t[191:0];
  endtask

  task automatic rand_data();
    set_data({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, 1'b1);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Reference model, evaluated mid-cycle for the upcoming rising edge.
  logic         m_active = 1'b0;
  logic         m_ov = 1'b0;
  logic [5:0]   m_cnt = '0;
  logic         m_xfer, m_ir;
  logic [5:0]   m_ru, m_rc;
  logic [127:0] m_upt, m_utk;
  logic [383:0] m_tmp;
  exp_t         m_e;

  always @(negedge clk) begin
    m_ir = m_active && (!m_ov || out_ready);
    if (chk_en) begin
      check("out_valid_d2", {383'h0, ov2}, {383'h0, m_ov});
      check("out_valid_d3", {383'h0, ov3}, {383'h0, m_ov});
      check("in_ready_d2", {383'h0, ir2}, {383'h0, m_ir});
      check("in_ready_d3", {383'h0, ir3}, {383'h0, m_ir});
      if (m_ov && out_ready) begin
        if (q.size() == 0) begin
          check("scoreboard_underflow", 384'h1, 384'h0);
        end else begin
          m_e = q.pop_front();
          check("shares_d2", {128'h0, so2}, {128'h0, m_e.s2});
          check("shares_d3", so3, m_e.s3);
          check("unmasked_d3", {256'h0, unmask(so3, 16, 3)}, {256'h0, m_e.u3});
          check("round_idx", {378'h0, ri2}, {378'h0, m_e.rnd});
          check("round_idx_d3", {378'h0, ri3}, {378'h0, m_e.rnd});
          check("last_round", {383'h0, lr2}, {383'h0, m_e.lst});
          check("last_round_d3", {383'h0, lr3}, {383'h0, m_e.lst});
        end
      end
    end
    if (rst) begin
      m_active = 1'b0;
      m_ov     = 1'b0;
      m_cnt    = '0;
      q.delete();
    end else begin
      m_xfer = in_valid && m_ir;
      m_ru   = start ? 6'd0 : m_cnt;
      if (m_xfer) begin
        m_rc    = RC_TAB[m_ru];
        m_tmp   = share_exp({128'h0, st2}, {64'h0, tk2}, 2, m_rc);
        m_e.s2  = m_tmp[255:0];
        m_e.s3  = share_exp(st3, tk3, 3, m_rc);
        m_upt   = unmask(st3, 16, 3);
        m_utk   = unmask({192'h0, tk3}, 8, 3);
        m_e.u3  = golden(m_upt, m_utk[63:0], m_rc);
        m_e.rnd = m_ru;
        m_e.lst = (m_ru == 6'd47);
        q.push_back(m_e);
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (start) begin
        m_active = !(m_xfer && m_ru == 6'd47);
        m_cnt    = m_xfer ? 6'd1 : 6'd0;
      end else if (m_xfer) begin
        m_cnt = m_cnt + 6'd1;
        if (m_ru == 6'd47) m_active = 1'b0;
      end
    end
  end

  vec_t         vt [4];
  logic [383:0] hold;
  int           n_last;

  initial begin
    vt[0] = '{pt: 128'h0, tk: 64'h0, rnd: 1'b0,
              exp: 128'h01000000_00000000_02000000_00000000};
    vt[1] = '{pt: {128{1'b1}}, tk: 64'h0, rnd: 1'b1,
              exp: 128'hFEFFFFFF_FFFFFFFF_FDFFFFFF_FFFFFFFF};
    vt[2] = '{pt: 128'h0, tk: 64'h01234567_89ABCDEF, rnd: 1'b1,
              exp: 128'h00234567_89ABCDEF_02000000_00000000};
    vt[3] = '{pt: 128'h00112233_44556677_8899AABB_CCDDEEFF, tk: 64'hFFEEDDCC_BBAA9988, rnd: 1'b1,
              exp: 128'hFEFFFFFF_FFFFFFFF_8A99AABB_CCDDEEFF};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_data(128'h0, 64'h0, 1'b0);
    @(posedge clk);
    chk_en = 1'b1;
    #1;
    @(negedge clk);
    check("reset_state_out_d2", {128'h0, so2}, 384'h0);
    check("reset_state_out_d3", so3, 384'h0);
    check("reset_round_idx", {378'h0, ri2}, 384'h0);
    check("reset_last_round", {383'h0, lr2}, 384'h0);
    next();
    rst = 1'b0;
    next();

    // Directed round-0 vectors against the unmasked golden.
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; in_valid = 1'b0;
      set_data(vt[i].pt, vt[i].tk, vt[i].rnd);
      next();
      start = 1'b0; in_valid = 1'b1;
      next();
      in_valid = 1'b0;
      @(negedge clk);
      check("vec_unmasked_d2", {256'h0, unmask({128'h0, so2}, 16, 2)}, {256'h0, vt[i].exp});
      check("vec_unmasked_d3", {256'h0, unmask(so3, 16, 3)}, {256'h0, vt[i].exp});
      check("vec_round_idx", {378'h0, ri2}, 384'h0);
      next();
    end

    // Full 48-round sequence, back to back.
    start = 1'b1;
    next();
    start = 1'b0; in_valid = 1'b1; n_last = 0;
    for (int i = 0; i < 50; i++) begin
      rand_data();
      next();
      if (ov2 && lr2) n_last++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_last", {383'h0, ir2}, 384'h0);
    check("last_round_count", 384'(n_last), 384'd1);
    next();

    // Backpressure: output holds and nothing is accepted.
    start = 1'b1;
    next();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      next();
    end
    out_ready = 1'b0;
    rand_data();
    @(negedge clk);
    hold = so3;
    for (int i = 0; i < 5; i++) begin
      next();
      rand_data();
      @(negedge clk);
      check("stall_stable", so3, hold);
      check("stall_in_ready", {383'h0, ir3}, 384'h0);
    end
    next();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      next();
    end
    in_valid = 1'b0;
    next();

    // Restart mid-sequence coinciding with a transfer.
    start = 1'b1;
    next();
    start = 1'b0; in_valid = 1'b1;
    rand_data();
    for (int i = 0; i < 20; i++) begin
      next();
      rand_data();
    end
    start = 1'b1;
    next();
    start = 1'b0;
    rand_data();
    @(negedge clk);
    check("restart_round_idx", {378'h0, ri2}, 384'h0);
    next();
    in_valid = 1'b0;
    @(negedge clk);
    check("restart_next_round", {378'h0, ri2}, 384'd1);
    next();

    // Synchronous reset in the middle of a sequence.
    start = 1'b1;
    next();
    start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_data();
      next();
    end
    rst = 1'b1;
    next();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {383'h0, ov2}, 384'h0);
    check("rst_state_out", so3, 384'h0);
    check("rst_in_ready", {383'h0, ir2}, 384'h0);
    for (int i = 0; i < 3; i++) next();
    start = 1'b1;
    next();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      next();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) next();

    check("scoreboard_drained", 384'(q.size()), 384'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
